// File: rtl/ddr3_pkg.sv
// ----------------------------------------------------------------------------
// ddr3_pkg
// Shared types and constants for the DDR3 read/write arbiter slice:
//   arb_state_t             arbiter FSM state encoding
//   AXI_ADDR_W / AXI_DATA_W AXI byte-address and data widths
//   BURST_BEATS/BURST_BYTES burst geometry (64 beats x 16 B)
//   FRAME_BYTES             one 1920x1080 frame at 2 B/pixel
//   FRAME0_BASE/FRAME1_BASE frame buffer base addresses
// ----------------------------------------------------------------------------
package ddr3_pkg;

   localparam int unsigned AXI_ADDR_W  = 28;
   localparam int unsigned AXI_DATA_W  = 128;
   localparam int unsigned BURST_BEATS = 64;
   localparam int unsigned BURST_BYTES = BURST_BEATS * (AXI_DATA_W / 8);
   localparam int unsigned FRAME_BYTES = 1920 * 1080 * 2;

   localparam logic [AXI_ADDR_W-1:0] FRAME0_BASE = 28'h000_0000;
   localparam logic [AXI_ADDR_W-1:0] FRAME1_BASE = 28'h040_0000;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_GO   = 3'd1,
      WR_WAIT = 3'd2,
      RD_GO   = 3'd3,
      RD_WAIT = 3'd4
   } arb_state_t;

endpackage

// File: rtl/frame_addr_gen.sv
// ----------------------------------------------------------------------------
// frame_addr_gen
// Per-path burst offset counter with frame wrap detection.
//   clk, rst        clock, asynchronous active-high reset
//   adv_i           burst completed: advance offset by one burst
//   clr_i           restart the frame (offset -> 0)
//   base_i          frame base that applies from the next cycle on
//   addr_o          registered burst address (base + offset)
//   wrap_c_o        combinational: this advance completes the frame
//   frame_start_c_o combinational: offset returns to 0 this cycle
// ----------------------------------------------------------------------------
module frame_addr_gen #(
   parameter int unsigned       ADDR_W      = ddr3_pkg::AXI_ADDR_W,
   parameter int unsigned       BURST_BYTES = ddr3_pkg::BURST_BYTES,
   parameter int unsigned       FRAME_BYTES = ddr3_pkg::FRAME_BYTES,
   parameter logic [ADDR_W-1:0] RST_ADDR    = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              adv_i,
   input  logic              clr_i,
   input  logic [ADDR_W-1:0] base_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              wrap_c_o,
   output logic              frame_start_c_o
);
   import ddr3_pkg::*;

   logic [ADDR_W-1:0] offset_q, offset_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] next_off;

   // Offset advance / wrap; a clear coinciding with a wrap is a single clear.
   always_comb begin
      next_off        = offset_q + ADDR_W'(BURST_BYTES);
      wrap_c_o        = adv_i && (next_off == ADDR_W'(FRAME_BYTES));
      frame_start_c_o = wrap_c_o || clr_i;
      offset_d        = offset_q;
      if (clr_i || wrap_c_o) begin
         offset_d = '0;
      end else if (adv_i) begin
         offset_d = next_off;
      end
   end

   // Kept apart from the offset logic: base_i may depend on frame_start_c_o.
   assign addr_d = base_i + offset_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         offset_q <= '0;
         addr_q   <= RST_ADDR;
      end else begin
         offset_q <= offset_d;
         addr_q   <= addr_d;
      end
   end

   assign addr_o = addr_q;

endmodule

// File: rtl/ddr3_rw_arbiter.sv
// ----------------------------------------------------------------------------
// ddr3_rw_arbiter
// Grants the single AXI master to either the write (UART) or read (HDMI) FIFO
// path and produces frame-relative burst addresses. Reads have priority; a
// run-length guard gives a pending write the master after MAX_RD_RUN reads.
//   sclk, s_rst        ui_clk, asynchronous active-high reset
//   calib_done         DDR3 calibration complete; gates new grants
//   wr_req / rd_req    level requests from the write / read FIFO paths
//   rd_frame_rst       restart the read frame (applied in IDLE)
//   wr_start/wr_addr   write burst start pulse and address
//   wr_done            write burst complete pulse
//   rd_start/rd_addr   read burst start pulse and address
//   rd_done            read burst complete pulse
//   busy               arbiter not in IDLE
//   wr_frame_done      last burst of a frame written
// Optional: define DOUBLE_BUFFER_EN for ping-pong frame buffers.
// ----------------------------------------------------------------------------
module ddr3_rw_arbiter #(
   parameter int unsigned       ADDR_W      = ddr3_pkg::AXI_ADDR_W,
   parameter int unsigned       BURST_BYTES = ddr3_pkg::BURST_BYTES,
   parameter int unsigned       FRAME_BYTES = ddr3_pkg::FRAME_BYTES,
   parameter logic [ADDR_W-1:0] FRAME0_BASE = ADDR_W'(ddr3_pkg::FRAME0_BASE),
   parameter logic [ADDR_W-1:0] FRAME1_BASE = ADDR_W'(ddr3_pkg::FRAME1_BASE),
   parameter int unsigned       MAX_RD_RUN  = 4
) (
   input  logic              sclk,
   input  logic              s_rst,
   input  logic              calib_done,
   input  logic              wr_req,
   input  logic              rd_req,
   input  logic              rd_frame_rst,
   output logic              wr_start,
   output logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_done,
   output logic              rd_start,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_done,
   output logic              busy,
   output logic              wr_frame_done
);
   import ddr3_pkg::*;

   localparam int unsigned RUN_W = $clog2(MAX_RD_RUN + 1);

   arb_state_t        state_q, state_d;
   logic [RUN_W-1:0]  rd_run_q, rd_run_d;
   logic              rd_pend_q, rd_pend_d;
   logic              wr_start_q, wr_start_d;
   logic              rd_start_q, rd_start_d;
   logic              busy_q, busy_d;
   logic              wr_frame_done_q;
   logic              wr_adv, rd_adv, rd_clr;
   logic              wr_wrap_c, wr_fstart_c, rd_wrap_c, rd_fstart_c;
   logic [ADDR_W-1:0] wr_base, rd_base;
   logic              unused_flags;

   // State register
   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state: arbitration happens only in IDLE with calibration done
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (calib_done) begin
               if (rd_req && (!wr_req || (rd_run_q < RUN_W'(MAX_RD_RUN)))) begin
                  state_d = RD_GO;
               end else if (wr_req) begin
                  state_d = WR_GO;
               end
            end
         end
         WR_GO:   state_d = WR_WAIT;
         WR_WAIT: if (wr_done) state_d = IDLE;
         RD_GO:   state_d = RD_WAIT;
         RD_WAIT: if (rd_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs and per-cycle control derived from the FSM
   always_comb begin
      wr_start_d = (state_q == WR_GO);
      rd_start_d = (state_q == RD_GO);
      busy_d     = (state_d != IDLE);
      // Done pulses only count in the matching WAIT state.
      wr_adv     = (state_q == WR_WAIT) && wr_done;
      rd_adv     = (state_q == RD_WAIT) && rd_done;
      // A pending frame restart lands in IDLE or on the edge entering it,
      // so an in-flight read burst never sees its address move.
      rd_clr     = (rd_pend_q || rd_frame_rst) &&
                   ((state_q == IDLE) || (state_d == IDLE));
      rd_pend_d  = rd_pend_q;
      if (rd_clr) begin
         rd_pend_d = 1'b0;
      end else if (rd_frame_rst) begin
         rd_pend_d = 1'b1;
      end
      rd_run_d = rd_run_q;
      if ((state_q == IDLE) && (state_d == RD_GO) && wr_req) begin
         rd_run_d = rd_run_q + RUN_W'(1);
      end else if ((state_q == IDLE) && ((state_d == WR_GO) || !wr_req)) begin
         rd_run_d = '0;
      end
   end

   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         wr_start_q      <= 1'b0;
         rd_start_q      <= 1'b0;
         busy_q          <= 1'b0;
         wr_frame_done_q <= 1'b0;
         rd_run_q        <= '0;
         rd_pend_q       <= 1'b0;
      end else begin
         wr_start_q      <= wr_start_d;
         rd_start_q      <= rd_start_d;
         busy_q          <= busy_d;
         wr_frame_done_q <= wr_wrap_c;
         rd_run_q        <= rd_run_d;
         rd_pend_q       <= rd_pend_d;
      end
   end

`ifdef DOUBLE_BUFFER_EN
   logic wr_buf_q, wr_buf_d;
   logic rd_buf_q, rd_buf_d;
   logic last_full_q, last_full_d;

   // Writer flips buffers per completed frame; reader latches the most
   // recently completed buffer at each read-frame start.
   always_comb begin
      wr_buf_d    = wr_buf_q ^ wr_wrap_c;
      last_full_d = wr_wrap_c ? wr_buf_q : last_full_q;
      rd_buf_d    = rd_fstart_c ? last_full_d : rd_buf_q;
   end

   assign wr_base = wr_buf_d ? FRAME1_BASE : FRAME0_BASE;
   assign rd_base = rd_buf_d ? FRAME1_BASE : FRAME0_BASE;

   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         wr_buf_q    <= 1'b0;
         rd_buf_q    <= 1'b0;
         last_full_q <= 1'b0;
      end else begin
         wr_buf_q    <= wr_buf_d;
         rd_buf_q    <= rd_buf_d;
         last_full_q <= last_full_d;
      end
   end

   assign unused_flags = ^{wr_fstart_c, rd_wrap_c};
`else
   assign wr_base      = FRAME0_BASE;
   assign rd_base      = FRAME0_BASE;
   assign unused_flags = ^{wr_fstart_c, rd_wrap_c, rd_fstart_c, FRAME1_BASE};
`endif

   frame_addr_gen #(
      .ADDR_W      (ADDR_W),
      .BURST_BYTES (BURST_BYTES),
      .FRAME_BYTES (FRAME_BYTES),
      .RST_ADDR    (FRAME0_BASE)
   ) u_wr_gen (
      .clk             (sclk),
      .rst             (s_rst),
      .adv_i           (wr_adv),
      .clr_i           (1'b0),
      .base_i          (wr_base),
      .addr_o          (wr_addr),
      .wrap_c_o        (wr_wrap_c),
      .frame_start_c_o (wr_fstart_c)
   );

   frame_addr_gen #(
      .ADDR_W      (ADDR_W),
      .BURST_BYTES (BURST_BYTES),
      .FRAME_BYTES (FRAME_BYTES),
      .RST_ADDR    (FRAME0_BASE)
   ) u_rd_gen (
      .clk             (sclk),
      .rst             (s_rst),
      .adv_i           (rd_adv),
      .clr_i           (rd_clr),
      .base_i          (rd_base),
      .addr_o          (rd_addr),
      .wrap_c_o        (rd_wrap_c),
      .frame_start_c_o (rd_fstart_c)
   );

   assign wr_start      = wr_start_q;
   assign rd_start      = rd_start_q;
   assign busy          = busy_q;
   assign wr_frame_done = wr_frame_done_q;

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ddr3_rw_arbiter
// Directed bench for ddr3_rw_arbiter: calibration gating, write address
// sequence, read/write grant ordering, read frame restart, reset mid-burst,
// full write frame wrap and calibration loss mid-burst.
// ----------------------------------------------------------------------------
module tb_ddr3_rw_arbiter;

   logic        sclk = 1'b0;
   logic        s_rst = 1'b1;
   logic        calib_done = 1'b0;
   logic        wr_req = 1'b0;
   logic        rd_req = 1'b0;
   logic        rd_frame_rst = 1'b0;
   logic        wr_done = 1'b0;
   logic        rd_done = 1'b0;
   logic        wr_start, rd_start, busy, wr_frame_done;
   logic [27:0] wr_addr, rd_addr;

   int checks = 0;
   int errors = 0;

   ddr3_rw_arbiter dut (
      .sclk          (sclk),
      .s_rst         (s_rst),
      .calib_done    (calib_done),
      .wr_req        (wr_req),
      .rd_req        (rd_req),
      .rd_frame_rst  (rd_frame_rst),
      .wr_start      (wr_start),
      .wr_addr       (wr_addr),
      .wr_done       (wr_done),
      .rd_start      (rd_start),
      .rd_addr       (rd_addr),
      .rd_done       (rd_done),
      .busy          (busy),
      .wr_frame_done (wr_frame_done)
   );

   always #5 sclk = ~sclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   // Wait (bounded) for either start pulse; reports which path and latency.
   task automatic wait_any(input string tag, output bit saw_wr, output int cyc);
      bit seen;
      seen   = 1'b0;
      saw_wr = 1'b0;
      cyc    = 0;
      while (!seen && cyc < 64) begin
         tick();
         cyc++;
         if (wr_start || rd_start) begin
            seen   = 1'b1;
            saw_wr = wr_start;
         end
      end
      chk({tag, "_start_seen"}, 32'(seen), 32'd1);
   endtask

   task automatic finish_burst(input bit is_wr, input int wait_cyc);
      repeat (wait_cyc) tick();
      if (is_wr) wr_done = 1'b1;
      else       rd_done = 1'b1;
      tick();
      wr_done = 1'b0;
      rd_done = 1'b0;
   endtask

   initial begin
      bit          saw_wr;
      bit          exp_wr;
      int          cyc;
      int          cnt;
      logic [27:0] exp_rd, exp_wa, exp_next;

      // Reset values
      repeat (3) tick();
      chk("rst_wr_start", 32'(wr_start), 0);
      chk("rst_rd_start", 32'(rd_start), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_frame_done", 32'(wr_frame_done), 0);
      chk("rst_wr_addr", 32'(wr_addr), 32'h0);
      chk("rst_rd_addr", 32'(rd_addr), 32'h0);

      // No grant while calibration is low
      s_rst  = 1'b0;
      wr_req = 1'b1;
      cnt    = 0;
      repeat (100) begin
         tick();
         if (wr_start || busy) cnt++;
      end
      chk("calib_gate", 32'(cnt), 0);
      calib_done = 1'b1;
      tick();
      chk("lat_cycle1_start", 32'(wr_start), 0);
      chk("lat_cycle1_busy", 32'(busy), 1);
      tick();
      chk("lat_cycle2_start", 32'(wr_start), 1);
      chk("wr0_addr", 32'(wr_addr), 32'h000);
      tick();
      chk("wr_start_width", 32'(wr_start), 0);
      repeat (16) tick();
      chk("wr0_busy_wait", 32'(busy), 1);
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
      chk("wr0_busy_after_done", 32'(busy), 0);
      chk("wr0_addr_next", 32'(wr_addr), 32'h400);

      // Bursts two and three
      wait_any("wr1", saw_wr, cyc);
      chk("wr1_is_wr", 32'(saw_wr), 1);
      chk("done_to_start", 32'(cyc), 2);
      chk("wr1_addr", 32'(wr_addr), 32'h400);
      finish_burst(1'b1, 19);
      wait_any("wr2", saw_wr, cyc);
      chk("wr2_addr", 32'(wr_addr), 32'h800);
      wr_req = 1'b0;
      finish_burst(1'b1, 19);
      repeat (3) tick();
      chk("idle_busy", 32'(busy), 0);

      // Both requests held: R R R R W R R R R W
      wr_req = 1'b1;
      rd_req = 1'b1;
      exp_rd = 28'h0;
      exp_wa = 28'hC00;
      for (int i = 0; i < 10; i++) begin
         exp_wr = (i == 4) || (i == 9);
         wait_any($sformatf("arb%0d", i), saw_wr, cyc);
         chk($sformatf("arb%0d_path", i), 32'(saw_wr), 32'(exp_wr));
         if (exp_wr) begin
            chk($sformatf("arb%0d_wr_addr", i), 32'(wr_addr), 32'(exp_wa));
            exp_wa = exp_wa + 28'h400;
         end else begin
            chk($sformatf("arb%0d_rd_addr", i), 32'(rd_addr), 32'(exp_rd));
            exp_rd = exp_rd + 28'h400;
         end
         finish_burst(saw_wr, 2);
      end
      wr_req = 1'b0;
      rd_req = 1'b0;
      repeat (2) tick();

      // Read frame restart applied immediately in IDLE
      rd_frame_rst = 1'b1;
      tick();
      rd_frame_rst = 1'b0;
      chk("frst_idle_addr", 32'(rd_addr), 32'h0);
      rd_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_any($sformatf("rd%0d", i), saw_wr, cyc);
         chk($sformatf("rd%0d_addr", i), 32'(rd_addr), 32'(i * 32'h400));
         finish_burst(1'b0, 2);
      end

      // Restart during RD_WAIT at 0x1000, plus a stray wr_done
      wait_any("rd4", saw_wr, cyc);
      chk("rd4_addr", 32'(rd_addr), 32'h1000);
      tick();
      rd_frame_rst = 1'b1;
      wr_done      = 1'b1;
      tick();
      rd_frame_rst = 1'b0;
      wr_done      = 1'b0;
      repeat (3) tick();
      chk("frst_hold_addr", 32'(rd_addr), 32'h1000);
      chk("stray_wr_done_busy", 32'(busy), 1);
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
      chk("frst_applied_addr", 32'(rd_addr), 32'h0);
      wait_any("rd5", saw_wr, cyc);
      chk("rd5_is_rd", 32'(saw_wr), 0);
      chk("rd5_addr", 32'(rd_addr), 32'h0);
      rd_req = 1'b0;
      finish_burst(1'b0, 2);

      // Write offset unaffected by the stray wr_done
      wr_req = 1'b1;
      wait_any("wr_after_stray", saw_wr, cyc);
      chk("wr_after_stray_addr", 32'(wr_addr), 32'h1400);
      finish_burst(1'b1, 2);

      // Reset asserted during WR_WAIT
      wait_any("wr_rst", saw_wr, cyc);
      chk("wr_rst_addr", 32'(wr_addr), 32'h1800);
      repeat (2) tick();
      s_rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_wr_addr", 32'(wr_addr), 32'h0);
      chk("midrst_rd_addr", 32'(rd_addr), 32'h0);
      chk("midrst_wr_start", 32'(wr_start), 0);
      tick();
      s_rst  = 1'b0;
      wr_req = 1'b0;
      tick();
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
      repeat (2) tick();
      chk("stray_after_rst_busy", 32'(busy), 0);
      chk("stray_after_rst_addr", 32'(wr_addr), 32'h0);

      // One full frame of writes
`ifdef DOUBLE_BUFFER_EN
      exp_next = 28'h040_0000;
`else
      exp_next = 28'h000_0000;
`endif
      wr_req = 1'b1;
      cnt    = 0;
      for (int i = 0; i < 4050; i++) begin
         wait_any("frame", saw_wr, cyc);
         if (i == 4049) begin
            chk("frame_last_addr", 32'(wr_addr), 32'h3F4400);
            wr_req = 1'b0;
         end
         finish_burst(1'b1, 0);
         if (wr_frame_done) cnt++;
         if (i == 4049) chk("frame_done_last", 32'(wr_frame_done), 1);
      end
      chk("frame_done_count", 32'(cnt), 1);
      tick();
      chk("frame_done_width", 32'(wr_frame_done), 0);
      chk("frame_wrap_addr", 32'(wr_addr), 32'(exp_next));

      // Calibration loss mid-burst
      wr_req = 1'b1;
      wait_any("cal", saw_wr, cyc);
      chk("cal_addr", 32'(wr_addr), 32'(exp_next));
      calib_done = 1'b0;
      finish_burst(1'b1, 3);
      chk("cal_done_busy", 32'(busy), 0);
      cnt = 0;
      repeat (10) begin
         tick();
         if (wr_start || busy) cnt++;
      end
      chk("cal_low_no_grant", 32'(cnt), 0);
      calib_done = 1'b1;
      tick();
      chk("cal_up_cycle1", 32'(wr_start), 0);
      tick();
      chk("cal_up_cycle2", 32'(wr_start), 1);
      chk("cal_up_addr", 32'(wr_addr), 32'(exp_next + 28'h400));
      wr_req = 1'b0;
      finish_burst(1'b1, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
